mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the word-wide data RAM.
- Takes byte/halfword/word requests from the CPU memory stage and drives the RAM's wren/address/write_data.
- Consumes the RAM's 1-cycle-latency read data, extracts and extends loads, and performs read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses without touching RAM.

Parameters:
- ADDR_W, default `RAM_ADDRESS_BITWIDTH (define.v): byte-address width of the RAM.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on an edge where req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; misaligned or illegal size.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- ram_wren  out  1  to RAM wren.
- ram_address  out  ADDR_W  to RAM address; always word-aligned (bits [1:0] = 0).
- ram_write_data  out  32  to RAM write_data.
- ram_data  in  32  from RAM data; word at the address sampled on the previous edge.

Behaviour:
- Data layout:
  - Little-endian: byte k of a word is [8k+7:8k].
  - Halfword at addr[1]=h is [16h+15:16h].
- Request capture: on acceptance, latch write, size, unsigned, addr and wdata into internal regs. Inputs are don't-care afterwards.
- Alignment error: size 11; size 01 with addr[0]=1; size 10 with addr[1:0]≠0.
- FSM states IDLE, ISSUE, DATA, RESP. Cycle 0 is the acceptance cycle.
  - IDLE: req_ready=1, ram_wren=0. Accept -> RESP with resp_err=1 if alignment error, else -> ISSUE.
  - ISSUE (cycle 1):
    - ram_address = {latched addr[ADDR_W-1:2], 2'b00}.
    - Word store: ram_wren=1, ram_write_data=wdata, next RESP.
    - Otherwise: ram_wren=0, next DATA.
  - DATA (cycle 2): ram_address held; ram_data is valid.
    - Load: register extracted/extended lane into resp_rdata, next RESP.
    - Sub-word store: ram_wren=1 and ram_write_data = ram_data with the addressed lane replaced by wdata[7:0] or wdata[15:0] (combinational merge), next RESP.
  - RESP: resp_valid=1 for exactly one cycle, ram_wren=0, req_ready=0, next IDLE.
- Latency: resp_valid asserts in:
  - misaligned/illegal: cycle 1;
  - word store: cycle 2;
  - load and sub-word store: cycle 3.
- Issue rate: next request is accepted one cycle after RESP, so a load occupies 4 cycles per request.
- ram_write_data is 0 whenever ram_wren=0.
- Reset (rstn=0 at an edge):
  - state IDLE; resp_valid, resp_err, resp_rdata = 0; ram_address = 0.
  - ram_wren is combinationally forced 0 while rstn=0, so reset mid-RMW or mid-word-store never writes.
  - In-flight requests are dropped with no response.
- No address range check; all ADDR_W addresses are legal.

Test Plan:
- Reset: hold rstn=0 for 2 cycles while req_valid=1 -> req_ready=0, resp_valid=0, ram_wren=0. After release, req_ready=1.
- Word store/load:
  - Store 0xDEADBEEF @0x10 -> ram_wren=1 in cycle 1 with address 0x10; resp_valid in cycle 2 with err=0.
  - Load word @0x10 -> resp_rdata=0xDEADBEEF in cycle 3.
- Sub-word store RMW:
  - Preload 0x11223344 @0x20; store byte 0xAA @0x21 -> write 0x1122AA44 in cycle 2.
  - Store half 0xBEEF @0x22 -> word becomes 0xBEEFAA44.
- Sub-word loads from word 0x80FF7F01 @0x30:
  - signed byte @0x32 -> 0xFFFFFFFF.
  - unsigned byte @0x33 -> 0x00000080.
  - signed half @0x30 -> 0x00007F01.
  - signed half @0x32 -> 0xFFFF80FF.
- Errors:
  - half @0x31, word @0x22, and size 11 -> resp_valid and resp_err=1 in cycle 1, resp_rdata=0, ram_wren never asserted.
- Reset mid-operation: byte store @0x21, drop rstn in cycle 2 -> no ram_wren pulse, RAM word unchanged, no resp_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end placed directly upstream of a word-wide data RAM
//   with one cycle of read latency. It accepts byte/halfword/word requests,
//   drives the RAM's wren/address/write_data, and returns a one-cycle
//   response pulse. Loads are extracted and zero- or sign-extended from the
//   RAM word. Sub-word stores use read-modify-write. Misaligned accesses and
//   the illegal size code are reported with resp_err, and the RAM is left
//   untouched.
//
// Ports
//   clk, rstn        clock; synchronous active-low reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_write        1 = store, 0 = load
//   req_size         00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned     zero-extend (1) or sign-extend (0) loads
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   resp_valid       one-cycle completion pulse
//   resp_err         misaligned / illegal size, valid with resp_valid
//   resp_rdata       load result (0 for stores and errors)
//   ram_wren, ram_address, ram_write_data   to the RAM
//   ram_data         RAM word for the address sampled on the previous edge

`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module mem_access_unit #(
  parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;

  // The upper address bits live in ram_address; only the lane offset is kept here.
  logic        lat_write;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        align_err;
  logic        wren_raw;
  logic [31:0] wdata_sel;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign req_ready = rstn & (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Alignment/size legality of the incoming request
  always_comb begin
    align_err = 1'b0;
    case (req_size)
      2'b00:   align_err = 1'b0;
      2'b01:   align_err = req_addr[0];
      2'b10:   align_err = (req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

  // Replace the addressed lane of the RAM word with the store data
  always_comb begin
    merged = ram_data;
    case (lat_size)
      2'b00:   merged[{lat_off, 3'b000} +: 8]     = lat_wdata[7:0];
      2'b01:   merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: merged = ram_data;
    endcase
  end

  // Extract the addressed lane of the RAM word and extend it to 32 bits
  always_comb begin
    load_byte = ram_data[{lat_off, 3'b000} +: 8];
    load_half = ram_data[{lat_off[1], 4'b0000} +: 16];
    load_val  = ram_data;
    case (lat_size)
      2'b00: begin
        if (lat_unsigned) begin
          load_val = {24'd0, load_byte};
        end else begin
          load_val = {{24{load_byte[7]}}, load_byte};
        end
      end
      2'b01: begin
        if (lat_unsigned) begin
          load_val = {16'd0, load_half};
        end else begin
          load_val = {{16{load_half[15]}}, load_half};
        end
      end
      default: load_val = ram_data;
    endcase
  end

  // RAM write strobe and data: word stores write in ISSUE, sub-word stores in DATA
  always_comb begin
    wren_raw  = 1'b0;
    wdata_sel = 32'd0;
    case (state)
      ISSUE: begin
        if (lat_write && (lat_size == 2'b10)) begin
          wren_raw  = 1'b1;
          wdata_sel = lat_wdata;
        end else begin
          wren_raw  = 1'b0;
          wdata_sel = 32'd0;
        end
      end
      DATA: begin
        if (lat_write) begin
          wren_raw  = 1'b1;
          wdata_sel = merged;
        end else begin
          wren_raw  = 1'b0;
          wdata_sel = 32'd0;
        end
      end
      default: begin
        wren_raw  = 1'b0;
        wdata_sel = 32'd0;
      end
    endcase
  end

  // Gating with rstn keeps a reset in the middle of a store from reaching the RAM.
  assign ram_wren       = wren_raw & rstn;
  assign ram_write_data = ram_wren ? wdata_sel : 32'd0;

  // Request FSM with registered response and RAM address
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'd0;
      ram_address  <= {ADDR_W{1'b0}};
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_off      <= 2'b00;
      lat_wdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          if (accept) begin
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_off      <= req_addr[1:0];
            lat_wdata    <= req_wdata;
            if (align_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state       <= ISSUE;
              ram_address <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ISSUE: begin
          if (lat_write && (lat_size == 2'b10)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= lat_write ? 32'd0 : load_val;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A word-wide RAM with one cycle
// of read latency is modelled next to the DUT. A byte-addressed reference
// memory produces the expected load values and the written words. Expected
// responses are queued when a request is issued. A monitor checks each one
// when resp_valid appears. The check covers error flag, data, latency, the
// number of RAM writes, and the write cycle, address and data.
module tb_mem_access_unit;
  localparam int ADDR_W    = 16;
  localparam int MEM_BYTES = 256;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_write_data;
  logic [31:0]       ram_data = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_wren(ram_wren), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_data(ram_data)
  );

  // RAM model: read returns the old word for the address sampled at this edge
  logic [31:0] ram_mem [0:(1<<(ADDR_W-2))-1];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address[ADDR_W-1:2]] <= ram_write_data;
    ram_data <= ram_mem[ram_address[ADDR_W-1:2]];
  end

  // Cycle counter and record of the last RAM write
  int                cyc = 0;
  int                wren_count = 0;
  int                wr_cyc = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [31:0]       wr_data = 32'd0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren) begin
      wren_count <= wren_count + 1;
      wr_cyc     <= cyc;
      wr_addr    <= ram_address;
      wr_data    <= ram_write_data;
    end
  end

  // Reference memory, byte addressed
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  typedef struct {
    logic              err;
    logic [31:0]       rdata;
    int                lat;
    int                acc;
    int                wc0;
    int                wr_n;
    int                wr_lat;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wword;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic is_err(input logic [1:0] size, input int addr);
    if (size == 2'd3) return 1'b1;
    return (addr % (1 << size)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input int addr);
    int base = addr & ~3;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  // Load value as an integer: sum the bytes, subtract 2^bits when signed and top bit set
  function automatic logic [31:0] ref_load(input int addr, input logic [1:0] size, input logic uns);
    int n = 1 << size;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[addr+i]) << (8*i);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each response
  always @(negedge clk) begin
    if (rstn && !ram_wren) check("wdata_zero_when_idle", ram_write_data, 32'd0);
    if (ram_wren) check("ram_addr_aligned", {30'd0, ram_address[1:0]}, 32'd0);
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp at cycle %0d: got resp_valid=1 expected no response", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_latency", cyc - mon_e.acc, mon_e.lat);
        check("ram_write_count", wren_count - mon_e.wc0, mon_e.wr_n);
        if (mon_e.wr_n == 1) begin
          check("write_cycle", wr_cyc - mon_e.acc, mon_e.wr_lat);
          check("write_addr", {16'd0, wr_addr}, {16'd0, mon_e.waddr});
          check("write_data", wr_data, mon_e.wword);
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] size, input logic uns, input int addr,
                        input logic [31:0] wd, input logic use_exp, input logic [31:0] exp_rd);
    exp_t e;
    int budget = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = ADDR_W'(addr); req_wdata = wd;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_timeout at cycle %0d: got req_ready=0 expected 1", cyc);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc; e.wc0 = wren_count; e.err = is_err(size, addr);
    e.wr_lat = 0; e.waddr = '0; e.wword = 32'd0; e.rdata = 32'd0;
    if (e.err) begin
      e.lat = 1; e.wr_n = 0;
    end else if (wr) begin
      for (int i = 0; i < (1 << size); i++) ref_mem[addr+i] = 8'(wd >> (8*i));
      e.wr_n = 1;
      e.lat = (size == 2'd2) ? 2 : 3;
      e.wr_lat = e.lat - 1;
      e.waddr = ADDR_W'(addr & ~3);
      e.wword = ref_word(addr);
    end else begin
      e.rdata = use_exp ? exp_rd : ref_load(addr, size, uns);
      e.lat = 3; e.wr_n = 0;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sbq.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    for (int i = 0; i < (1<<(ADDR_W-2)); i++) ram_mem[i] = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;

    // Reset held for two edges with a request pending
    rstn = 1'b0; req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_ram_wren", {31'd0, ram_wren}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_ram_address", {16'd0, ram_address}, 32'd0);
    rstn = 1'b1; req_valid = 1'b0;
    #1 check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Word store / load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF);

    // Sub-word read-modify-write stores
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'd0);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 1'b0, 32'd0);
    drain();
    check("rmw_byte_word", ram_mem[8], 32'h1122AA44);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 1'b0, 32'd0);
    drain();
    check("rmw_half_word", ram_mem[8], 32'hBEEFAA44);

    // Sub-word loads with extension
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01, 1'b0, 32'd0);
    do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'd0, 1'b1, 32'hFFFFFFFF);
    do_req(1'b0, 2'd0, 1'b1, 32'h33, 32'd0, 1'b1, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h30, 32'd0, 1'b1, 32'h00007F01);
    do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'd0, 1'b1, 32'hFFFF80FF);

    // Misaligned and illegal accesses
    do_req(1'b0, 2'd1, 1'b0, 32'h31, 32'd0, 1'b0, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h22, 32'h12345678, 1'b0, 32'd0);
    do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'd0);
    drain();

    // Reset in cycle 2 of a byte store: no write, no response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = ADDR_W'(32'h21); req_wdata = 32'h00000055;
    wc = wren_count;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("midrst_wren", {31'd0, ram_wren}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_write_count", wren_count - wc, 32'd0);
    check("midrst_ram_word", ram_mem[8], 32'hBEEFAA44);
    check("midrst_ready_after", {31'd0, req_ready}, 32'd1);

    // Randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      int sel = $urandom % 8;
      logic [1:0] size;
      int addr = $urandom % MEM_BYTES;
      size = (sel < 3) ? 2'd0 : (sel < 5) ? 2'd1 : (sel < 7) ? 2'd2 : 2'd3;
      if (size != 2'd3 && ($urandom % 4) != 0) addr = addr & ~((1 << size) - 1);
      do_req(1'($urandom % 2), size, 1'($urandom % 2), addr, $urandom, 1'b0, 32'd0);
    end
    drain();

    // Final RAM contents against the reference memory
    for (int w = 0; w < MEM_BYTES/4; w++) check("final_mem", ram_mem[w], ref_word(w*4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
